// File: rtl/colbuf_pkg.sv
// Shared types for the ping-pong column buffer controller.
// Defines the per-bank state encoding, bank identifiers and the
// read-return pipeline entry.
package colbuf_pkg;

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      FILLING  = 2'd1,
      FULL     = 2'd2,
      DRAINING = 2'd3
   } bank_state_t;

   localparam logic BANK_A = 1'b0;
   localparam logic BANK_B = 1'b1;

   // One entry of the read-latency pipe: a read was issued, whether it was
   // the final row of the bank, and which bank's read port holds the data.
   typedef struct packed {
      logic valid;
      logic last;
      logic bank;
   } rd_pipe_t;

endpackage

// File: rtl/colbuf_bank_fsm.sv
// Per-bank occupancy tracker: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
// writable/readable are registered alongside the state so the top level sees
// clean flop outputs when choosing whether to accept a row or issue a read.
module colbuf_bank_fsm
   import colbuf_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic wrBeat,    // a row is written to this bank this cycle
   input  logic wrDone,    // that row is the last one of the block
   input  logic rdBeat,    // a read is issued to this bank this cycle
   input  logic rdDone,    // that read is the last one of the block
   output logic writable,
   output logic readable
);

   bank_state_t state;

   // Bank state machine with registered writable/readable flags.
   // NOTE: every flop here and elsewhere is assigned with <= so all state
   // updates see the pre-edge values, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= EMPTY;
         writable <= 1'b1;
         readable <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (wrBeat) begin
                  if (wrDone) begin
                     state    <= FULL;
                     writable <= 1'b0;
                     readable <= 1'b1;
                  end else begin
                     state <= FILLING;
                  end
               end
            end
            FILLING: begin
               if (wrDone) begin
                  state    <= FULL;
                  writable <= 1'b0;
                  readable <= 1'b1;
               end
            end
            FULL: begin
               if (rdBeat) begin
                  if (rdDone) begin
                     state    <= EMPTY;
                     writable <= 1'b1;
                     readable <= 1'b0;
                  end else begin
                     state <= DRAINING;
                  end
               end
            end
            DRAINING: begin
               if (rdDone) begin
                  state    <= EMPTY;
                  writable <= 1'b1;
                  readable <= 1'b0;
               end
            end
            default: begin
               state    <= EMPTY;
               writable <= 1'b1;
               readable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/columnbuffer_pingpong_ctrl.sv
// Ping-pong controller for the two-bank column buffer.
// One bank fills from the feature producer (port 1 writes) while the other
// drains to the feature adder (port 2 reads); roles swap on block completion.
// A rdLatency-deep pipe aligns drain_valid/drain_last/read_sel with RAM data.
// Optional: define COLBUF_PERF_CNT_EN to add saturating performance counters.
module columnbuffer_pingpong_ctrl
   import colbuf_pkg::*;
#(
   parameter  int k         = 1024,
   parameter  int rdLatency = 2,
   localparam int addrW     = $clog2(k)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fill_valid,
   output logic             fill_ready,
   input  logic             drain_ready,
   output logic             drain_valid,
   output logic             drain_last,
   output logic             enableA,
   output logic             enableB,
   output logic             writeEnableA1,
   output logic             writeEnableB1,
   output logic [addrW-1:0] addressWr,
   output logic [addrW-1:0] addressRd,
   output logic             read_sel
`ifdef COLBUF_PERF_CNT_EN
   ,
   output logic [31:0]      perf_fill_stall,
   output logic [31:0]      perf_drain_idle,
   output logic [31:0]      perf_swaps
`endif
);

   logic             fillBank;
   logic             drainBank;
   logic [addrW-1:0] wrCnt;
   logic [addrW-1:0] rdCnt;

   logic writableA, writableB;
   logic readableA, readableB;
   logic fillWritable, drainReadable;
   logic wrAccept, wrLast;
   logic rdIssue, rdLast;
   logic rdIssueA, rdIssueB;
   logic inFlightA, inFlightB;

   rd_pipe_t rdPipe [rdLatency];

   assign fillWritable  = (fillBank  == BANK_B) ? writableB : writableA;
   assign drainReadable = (drainBank == BANK_B) ? readableB : readableA;

   assign fill_ready = fillWritable & ~rst;
   assign wrAccept   = fill_valid & fill_ready;
   assign wrLast     = (wrCnt == addrW'(k - 1));

   assign rdIssue  = drain_ready & drainReadable & ~rst;
   assign rdLast   = (rdCnt == addrW'(k - 1));
   assign rdIssueA = rdIssue & (drainBank == BANK_A);
   assign rdIssueB = rdIssue & (drainBank == BANK_B);

   assign writeEnableA1 = wrAccept & (fillBank == BANK_A);
   assign writeEnableB1 = wrAccept & (fillBank == BANK_B);
   assign addressWr     = wrCnt;
   assign addressRd     = rdCnt;

   colbuf_bank_fsm u_bankA (
      .clk      (clk),
      .rst      (rst),
      .wrBeat   (writeEnableA1),
      .wrDone   (writeEnableA1 & wrLast),
      .rdBeat   (rdIssueA),
      .rdDone   (rdIssueA & rdLast),
      .writable (writableA),
      .readable (readableA)
   );

   colbuf_bank_fsm u_bankB (
      .clk      (clk),
      .rst      (rst),
      .wrBeat   (writeEnableB1),
      .wrDone   (writeEnableB1 & wrLast),
      .rdBeat   (rdIssueB),
      .rdDone   (rdIssueB & rdLast),
      .writable (writableB),
      .readable (readableB)
   );

   // Write row counter and fill pointer; the pointer flips on the last row.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrCnt    <= '0;
         fillBank <= BANK_A;
      end else if (wrAccept) begin
         if (wrLast) begin
            wrCnt    <= '0;
            fillBank <= ~fillBank;
         end else begin
            wrCnt <= wrCnt + 1'b1;
         end
      end
   end

   // Read row counter and drain pointer; the pointer flips on the last issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdCnt     <= '0;
         drainBank <= BANK_A;
      end else if (rdIssue) begin
         if (rdLast) begin
            rdCnt     <= '0;
            drainBank <= ~drainBank;
         end else begin
            rdCnt <= rdCnt + 1'b1;
         end
      end
   end

   // Read-return pipe: carries {valid, last, bank} for rdLatency cycles.
   // NOTE: every pipe stage is reset so in-flight reads are dropped on rst;
   // the bank RAM contents themselves are never reset, only their state.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < rdLatency; i++) begin
            rdPipe[i] <= '0;
         end
      end else begin
         rdPipe[0].valid <= rdIssue;
         rdPipe[0].last  <= rdIssue & rdLast;
         rdPipe[0].bank  <= rdIssue & drainBank;
         for (int i = 1; i < rdLatency; i++) begin
            rdPipe[i] <= rdPipe[i-1];
         end
      end
   end

   assign drain_valid = rdPipe[rdLatency-1].valid;
   assign drain_last  = rdPipe[rdLatency-1].last;
   assign read_sel    = rdPipe[rdLatency-1].bank;

   // Banks stay enabled while any of their reads is still travelling the pipe.
   // NOTE: both flags get a default before the loop so no latch is inferred.
   always_comb begin
      inFlightA = 1'b0;
      inFlightB = 1'b0;
      for (int i = 0; i < rdLatency; i++) begin
         if (rdPipe[i].valid) begin
            if (rdPipe[i].bank == BANK_B) inFlightB = 1'b1;
            else                          inFlightA = 1'b1;
         end
      end
   end

   assign enableA = writeEnableA1 | rdIssueA | inFlightA;
   assign enableB = writeEnableB1 | rdIssueB | inFlightB;

`ifdef COLBUF_PERF_CNT_EN
   // Saturating performance counters: fill stalls, idle drain slots, swaps.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fill_stall <= '0;
         perf_drain_idle <= '0;
         perf_swaps      <= '0;
      end else begin
         if (fill_valid && !fill_ready && perf_fill_stall != '1)
            perf_fill_stall <= perf_fill_stall + 1'b1;
         if (drain_ready && !drainReadable && perf_drain_idle != '1)
            perf_drain_idle <= perf_drain_idle + 1'b1;
         if (wrAccept && wrLast && perf_swaps != '1)
            perf_swaps <= perf_swaps + 1'b1;
      end
   end
`endif

endmodule
